// File: rtl/id_ex_lanes.sv
// rtl/id_ex_lanes.sv - N-lane decode-to-execute pipeline register
// Selective flush, stall hold/bubble insertion, sticky side-band and saturating perf counters.
module id_ex_lanes #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 160,
  parameter int STICKY_W = 1,
  parameter int CNT_W    = 32,
  parameter int KEEP_W   = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    flush_cause,
  input  logic [KEEP_W-1:0]       flush_keep,
  input  logic                    stall_id,
  input  logic                    stall_ex,
  input  logic [LANES-1:0]        valid_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [STICKY_W-1:0]     sticky_i,
  output logic [LANES-1:0]        valid_o,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic [STICKY_W-1:0]     sticky_o,
  output logic [CNT_W-1:0]        bubble_cnt_o,
  output logic [CNT_W-1:0]        flush_cnt_o
);

  typedef enum logic [2:0] {
    ACT_EXC,
    ACT_MISP,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_t;

  logic [LANES-1:0]        r_valid;
  logic [LANES*DATA_W-1:0] r_data;
  logic [STICKY_W-1:0]     r_sticky;
  logic [CNT_W-1:0]        r_bubble_cnt;
  logic [CNT_W-1:0]        r_flush_cnt;

  act_t                    w_act;
  logic [LANES-1:0]        w_keep;
  logic [LANES-1:0]        w_valid_nxt;
  logic [LANES*DATA_W-1:0] w_data_nxt;
  logic [STICKY_W-1:0]     w_sticky_nxt;

  always_comb begin
    w_act = ACT_LOAD;
    if (flush && !flush_cause)  w_act = ACT_EXC;
    else if (flush)             w_act = ACT_MISP;
    else if (stall_ex)          w_act = ACT_HOLD;
    else if (stall_id)          w_act = ACT_BUBBLE;
  end

  // A keep count above LANES naturally keeps every lane, so no explicit clamp is needed.
  always_comb begin
    w_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      w_keep[k] = (32'(flush_keep) > 32'(k));
    end
  end

  always_comb begin
    w_valid_nxt  = r_valid;
    w_data_nxt   = r_data;
    w_sticky_nxt = r_sticky;
    case (w_act)
      ACT_EXC: begin
        w_valid_nxt  = '0;
        w_sticky_nxt = '0;
      end
      ACT_MISP: begin
        w_valid_nxt  = valid_i & w_keep;
        w_sticky_nxt = sticky_i;
      end
      ACT_BUBBLE: begin
        w_valid_nxt  = '0;
      end
      ACT_LOAD: begin
        w_valid_nxt  = valid_i;
        w_sticky_nxt = sticky_i;
      end
      default: ;
    endcase
    // Invalid lanes always store zero payload; held lanes were already masked on capture.
    if (w_act != ACT_HOLD) begin
      for (int k = 0; k < LANES; k++) begin
        w_data_nxt[k*DATA_W +: DATA_W] = w_valid_nxt[k] ? data_i[k*DATA_W +: DATA_W] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= '0;
      r_data   <= '0;
      r_sticky <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_data   <= w_data_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if ((w_act == ACT_EXC || w_act == ACT_MISP) && !(&r_flush_cnt))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (w_act == ACT_BUBBLE && !(&r_bubble_cnt))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign valid_o      = r_valid;
  assign data_o       = r_data;
  assign sticky_o     = r_sticky;
  assign bubble_cnt_o = r_bubble_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_lanes.sv
// tb/tb_id_ex_lanes.sv - directed vector bench for id_ex_lanes
module tb_id_ex_lanes;

  localparam int LANES = 2;
  localparam int DW    = 16;
  localparam int KW    = $clog2(LANES + 1);

  logic             clk = 1'b0;
  logic             resetn;
  logic             flush, flush_cause, stall_id, stall_ex;
  logic [KW-1:0]    flush_keep;
  logic [LANES-1:0] valid_i;
  logic [LANES*DW-1:0] data_i;
  logic [0:0]       sticky_i;
  logic [LANES-1:0] valid_o, valid_o_s;
  logic [LANES*DW-1:0] data_o, data_o_s;
  logic [0:0]       sticky_o, sticky_o_s;
  logic [7:0]       bubble_cnt_o, flush_cnt_o;
  logic [1:0]       bubble_cnt_s, flush_cnt_s;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_lanes #(.LANES(LANES), .DATA_W(DW), .STICKY_W(1), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .flush_cause(flush_cause),
    .flush_keep(flush_keep), .stall_id(stall_id), .stall_ex(stall_ex),
    .valid_i(valid_i), .data_i(data_i), .sticky_i(sticky_i),
    .valid_o(valid_o), .data_o(data_o), .sticky_o(sticky_o),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  id_ex_lanes #(.LANES(LANES), .DATA_W(DW), .STICKY_W(1), .CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .flush(flush), .flush_cause(flush_cause),
    .flush_keep(flush_keep), .stall_id(stall_id), .stall_ex(stall_ex),
    .valid_i(valid_i), .data_i(data_i), .sticky_i(sticky_i),
    .valid_o(valid_o_s), .data_o(data_o_s), .sticky_o(sticky_o_s),
    .bubble_cnt_o(bubble_cnt_s), .flush_cnt_o(flush_cnt_s)
  );

  typedef struct {
    logic        fl;
    logic        cause;
    logic [1:0]  keep;
    logic        sid;
    logic        sex;
    logic [1:0]  vi;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        si;
    logic [1:0]  ev;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        es;
    int          eb;
    int          ef;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic cause, input logic [1:0] keep,
                       input logic sid, input logic sex, input logic [1:0] vi,
                       input logic [15:0] d0, input logic [15:0] d1, input logic si);
    flush = fl; flush_cause = cause; flush_keep = keep;
    stall_id = sid; stall_ex = sex; valid_i = vi;
    data_i = {d1, d0}; sticky_i = si;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ev, input logic [15:0] e0,
                         input logic [15:0] e1, input logic es, input int eb, input int ef);
    int eb_s, ef_s;
    eb_s = (eb > 3) ? 3 : eb;
    ef_s = (ef > 3) ? 3 : ef;
    chk({tag, ".valid"},  64'(valid_o), 64'(ev));
    chk({tag, ".data0"},  64'(data_o[DW-1:0]), 64'(e0));
    chk({tag, ".data1"},  64'(data_o[2*DW-1:DW]), 64'(e1));
    chk({tag, ".sticky"}, 64'(sticky_o), 64'(es));
    chk({tag, ".bubble"}, 64'(bubble_cnt_o), 64'(eb));
    chk({tag, ".flush"},  64'(flush_cnt_o), 64'(ef));
    chk({tag, ".bubble_sat"}, 64'(bubble_cnt_s), 64'(eb_s));
    chk({tag, ".flush_sat"},  64'(flush_cnt_s), 64'(ef_s));
  endtask

  initial begin
    //            fl cs kp si se vi    d0     d1     s  ev     e0     e1     es eb ef
    vecs[0]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,2'b11,16'hA,16'hB,1'b1, 2'b11,16'hA,16'hB,1'b1,0,0};
    vecs[1]  = '{1'b0,1'b0,2'd0,1'b1,1'b0,2'b11,16'hE,16'hF,1'b0, 2'b00,16'h0,16'h0,1'b1,1,0};
    vecs[2]  = '{1'b0,1'b0,2'd0,1'b1,1'b0,2'b11,16'hE,16'hF,1'b0, 2'b00,16'h0,16'h0,1'b1,2,0};
    vecs[3]  = '{1'b0,1'b0,2'd0,1'b1,1'b0,2'b11,16'hE,16'hF,1'b0, 2'b00,16'h0,16'h0,1'b1,3,0};
    vecs[4]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,2'b11,16'h3,16'h4,1'b0, 2'b11,16'h3,16'h4,1'b0,3,0};
    vecs[5]  = '{1'b0,1'b0,2'd0,1'b1,1'b1,2'b11,16'h1,16'h2,1'b1, 2'b11,16'h3,16'h4,1'b0,3,0};
    vecs[6]  = '{1'b1,1'b1,2'd1,1'b0,1'b0,2'b11,16'hC,16'hD,1'b1, 2'b01,16'hC,16'h0,1'b1,3,1};
    vecs[7]  = '{1'b1,1'b0,2'd0,1'b0,1'b1,2'b11,16'h1,16'h2,1'b1, 2'b00,16'h0,16'h0,1'b0,3,2};
    vecs[8]  = '{1'b0,1'b0,2'd0,1'b0,1'b0,2'b01,16'h5,16'h6,1'b1, 2'b01,16'h5,16'h0,1'b1,3,2};
    vecs[9]  = '{1'b1,1'b1,2'd2,1'b0,1'b0,2'b10,16'h7,16'h8,1'b0, 2'b10,16'h0,16'h8,1'b0,3,3};
    vecs[10] = '{1'b1,1'b1,2'd3,1'b0,1'b1,2'b11,16'h9,16'hA,1'b1, 2'b11,16'h9,16'hA,1'b1,3,4};
    vecs[11] = '{1'b1,1'b1,2'd0,1'b1,1'b0,2'b11,16'h1,16'h2,1'b0, 2'b00,16'h0,16'h0,1'b0,3,5};
    vecs[12] = '{1'b0,1'b0,2'd0,1'b0,1'b0,2'b11,16'h1,16'h2,1'b1, 2'b11,16'h1,16'h2,1'b1,3,5};
    vecs[13] = '{1'b0,1'b0,2'd0,1'b1,1'b0,2'b00,16'h3,16'h3,1'b0, 2'b00,16'h0,16'h0,1'b1,4,5};

    resetn = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 2'b00, 16'h0, 16'h0, 1'b0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].cause, vecs[i].keep, vecs[i].sid, vecs[i].sex,
            vecs[i].vi, vecs[i].d0, vecs[i].d1, vecs[i].si);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].e0, vecs[i].e1,
                 vecs[i].es, vecs[i].eb, vecs[i].ef);
    end

    // Five back-to-back bubbles: wide counter keeps counting, 2-bit one pins at 3.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 16'h1, 16'h1, 1'b0);
      @(posedge clk);
    end
    #1 chk_all("sat", 2'b00, 16'h0, 16'h0, 1'b1, 9, 5);

    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'b11, 16'h5, 16'h6, 1'b1);
    @(posedge clk);
    #1 chk_all("preload", 2'b11, 16'h5, 16'h6, 1'b1, 9, 5);

    // Asynchronous reset between edges must clear immediately.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_all("async_rst", 2'b00, 16'h0, 16'h0, 1'b0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1 chk_all("post_rst", 2'b11, 16'h5, 16'h6, 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_lanes.md
# id_ex_lanes

Parametrised decode-to-execute pipeline register for an N-lane issue core. It replaces the fixed dual-issue ID/EX register. Each lane carries an opaque payload plus a valid bit. The block inserts bubbles and holds on stall, and applies selective flush on exception or branch misprediction. It also keeps a sticky side-band field across bubbles and counts bubbles and flushes for performance monitoring.

## Interface
Parameters:
- LANES, 2, number of issue lanes (1..4); lane 0 is oldest.
- DATA_W, 160, payload bits per lane (aluop, alusel, operands, waddr, we, exception type, BPU pack, ...).
- STICKY_W, 1, side-band bits held through bubbles (e.g. next-inst-in-delay-slot).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  reset; asynchronous, active-low.
- flush  in  1  flush request.
- flush_cause  in  1  0 = exception, 1 = failed branch prediction.
- flush_keep  in  $clog2(LANES+1)  on mispredict flush, number of oldest lanes to keep (0..LANES).
- stall_id  in  1  decode stage stalled.
- stall_ex  in  1  execute stage stalled.
- valid_i  in  LANES  per-lane valid from decode.
- data_i  in  LANES*DATA_W  lane payloads; lane k at [k*DATA_W +: DATA_W].
- sticky_i  in  STICKY_W  side-band from decode.
- valid_o  out  LANES  registered per-lane valid.
- data_o  out  LANES*DATA_W  registered payloads.
- sticky_o  out  STICKY_W  registered side-band.
- bubble_cnt_o  out  CNT_W  cycles in which a bubble was inserted (saturating).
- flush_cnt_o  out  CNT_W  flush events taken (saturating).

## Operation
Per-cycle action, in strict priority order:
1. **EXC** (flush & flush_cause=0): all valid_o ← 0, all data_o ← 0, sticky_o ← 0.
2. **MISP** (flush & flush_cause=1):
   - lanes k < flush_keep load valid_i[k] and data_i[k];
   - lanes k ≥ flush_keep get valid ← 0 and data ← 0;
   - sticky_o ← sticky_i.
   - flush_keep > LANES is treated as LANES.
3. **HOLD** (stall_ex=1): all outputs keep their values.
4. **BUBBLE** (stall_id=1, stall_ex=0):
   - all valid_o ← 0, data_o ← 0;
   - sticky_o keeps its value (not cleared).
5. **LOAD** (otherwise): valid_o ← valid_i, data_o ← data_i, sticky_o ← sticky_i.

Rules that apply in every state:
- A lane whose captured valid bit is 0 has its data stored as 0, so data_o of an invalid lane always reads 0.
- Payload width, lane count and lane order are preserved bit-exact; no compaction of lanes.

Counters:
- flush_cnt_o increments by 1 on EXC or MISP.
- bubble_cnt_o increments by 1 on BUBBLE only.
- Both saturate at 2^CNT_W−1 and clear only on reset.

## Timing
- Latency: 1 cycle, input to output.
- All state updates on posedge clk.
- Reset: asynchronous assertion, synchronous deassertion by the system. While resetn=0: valid_o=0, data_o=0, sticky_o=0, bubble_cnt_o=0, flush_cnt_o=0.
- Flush overrides stall in the same cycle. A flush during stall_ex still clears (EXC) or partially loads (MISP).
- stall_id=0 with stall_ex=1 is a legal combination and takes HOLD.
- A MISP cycle with flush_keep=LANES is a full load, but still counts as a flush and not as a bubble.
- Back-to-back flushes each count.
- After a reset mid-operation, the first active edge behaves per the priority list with no residual state.

## Test plan
- Reset → all outputs 0.
- Release reset, LANES=2, drive valid_i=2'b11, data lane0=0xA, lane1=0xB, sticky_i=1, no stall → next cycle valid_o=11, data lane0=0xA, lane1=0xB, sticky_o=1.
- From that state, stall_id=1, stall_ex=0 for 3 cycles → valid_o=00, data_o=0, sticky_o stays 1, bubble_cnt_o=3.
- stall_id=1, stall_ex=1 with new inputs → outputs unchanged, bubble_cnt_o unchanged.
- flush=1, flush_cause=1, flush_keep=1, valid_i=11, data 0xC/0xD → valid_o=01, lane0=0xC, lane1=0, flush_cnt_o increments by 1.
- flush=1, flush_cause=0 while stall_ex=1 → all outputs 0 including sticky_o.
- Counter saturation with CNT_W=2: 5 consecutive bubbles → bubble_cnt_o=3.
- Assert resetn=0 asynchronously mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
